// File: rtl/mem_pkg.sv
// Shared definitions for the bidirectional-bus scratch SRAM controller.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/rd_pipe.sv
// Read-return pipeline: RD_LAT stages of valid+data, valid flushed asynchronously.
module rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [DATA_W-1:0] din,
    output logic              valid,
    output logic [DATA_W-1:0] dout
);

    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Data needs no reset: it is only observed while the matching valid bit is set.
    always_ff @(posedge clk) begin
        dat_q[0] <= din;
        for (int i = 1; i < RD_LAT; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    assign valid = vld_q[RD_LAT-1];
    assign dout  = dat_q[RD_LAT-1];

endmodule

// File: rtl/bidir_sram_ctrl.sv
// Single-port scratch SRAM on a shared bidirectional bus with byte enables,
// configurable read latency, post-reset zero fill and protocol-error pulse.
//
//   state    | meaning
//   ST_CLEAR | zero-filling one word per cycle after reset; requests ignored
//   ST_IDLE  | serving read/write requests
module bidir_sram_ctrl
    import mem_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 4,
    parameter  int RD_LAT = 1,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   be,
    inout  wire  [DATA_W-1:0] data_io,
    output logic              busy,
    output logic              rd_valid,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX || (DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_param
        $error("bidir_sram_ctrl: RD_LAT must be 1..%0d and DATA_W a multiple of 8", RD_LAT_MAX);
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              rd_issue;
    logic              err_d;
    logic              req_wr;
    logic              req_rd;
    logic [DATA_W-1:0] rd_data;

    assign req_wr = cs && we && !re;
    assign req_rd = cs && re && !we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            err       <= 1'b0;
        end else begin
            state_q <= state_d;
            err     <= err_d;
            if (state_q == ST_CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_addr  = addr;
        mem_wdata = data_io;
        mem_be    = '0;
        rd_issue  = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = '0;
                mem_be    = '1;
                err_d     = cs && (we || re);
                if (&clr_cnt_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs && we && re) begin
                    err_d = 1'b1;
                end else if (req_wr) begin
                    // The bus is ours while read data is out: a write now would latch garbage.
                    if (rd_valid) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        mem_be = be;
                    end
                end else if (req_rd) begin
                    rd_issue = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk   (clk),
        .rst   (rst),
        .issue (rd_issue),
        .din   (mem[addr]),
        .valid (rd_valid),
        .dout  (rd_data)
    );

    assign busy    = (state_q == ST_CLEAR);
    assign data_io = rd_valid ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bidir_sram_ctrl.sv
// Scoreboard bench: instance A (8-bit, RD_LAT=1) and instance B (16-bit, RD_LAT=3).
module tb_bidir_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cs_r [2];
    logic        we_r [2];
    logic        re_r [2];
    logic        oe_r [2];
    logic [3:0]  addr_r [2];
    logic [1:0]  be_r [2];
    logic [15:0] drv_r [2];

    wire  [7:0]  bus_a;
    wire  [15:0] bus_b;
    logic        busy_a, rdv_a, err_a;
    logic        busy_b, rdv_b, err_b;

    assign bus_a = oe_r[0] ? drv_r[0][7:0] : 8'hzz;
    assign bus_b = oe_r[1] ? drv_r[1] : 16'hzzzz;

    bidir_sram_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs_r[0]),
        .we       (we_r[0]),
        .re       (re_r[0]),
        .addr     (addr_r[0]),
        .be       (be_r[0][0:0]),
        .data_io  (bus_a),
        .busy     (busy_a),
        .rd_valid (rdv_a),
        .err      (err_a)
    );

    bidir_sram_ctrl #(.DATA_W(16), .ADDR_W(4), .RD_LAT(3)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs_r[1]),
        .we       (we_r[1]),
        .re       (re_r[1]),
        .addr     (addr_r[1]),
        .be       (be_r[1]),
        .data_io  (bus_b),
        .busy     (busy_b),
        .rd_valid (rdv_b),
        .err      (err_b)
    );

    typedef struct packed {
        logic [31:0] due;
        logic [15:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: a read expected at cycle 'due' must show rd_valid with the right data
    // then and only then.
    always @(negedge clk) begin
        if (q_a.size() > 0 && q_a[0].due == 32'(cyc)) begin
            check("a_rd_valid", {15'b0, rdv_a}, 16'h0001);
            check("a_rd_data", {8'h00, bus_a}, q_a[0].data);
            q_a.delete(0);
        end else if (rdv_a) begin
            check("a_rd_spurious", {15'b0, rdv_a}, 16'h0000);
        end
    end

    always @(negedge clk) begin
        if (q_b.size() > 0 && q_b[0].due == 32'(cyc)) begin
            check("b_rd_valid", {15'b0, rdv_b}, 16'h0001);
            check("b_rd_data", bus_b, q_b[0].data);
            q_b.delete(0);
        end else if (rdv_b) begin
            check("b_rd_spurious", {15'b0, rdv_b}, 16'h0000);
        end
    end

    task automatic drive_idle(input int inst);
        cs_r[inst]   = 1'b0;
        we_r[inst]   = 1'b0;
        re_r[inst]   = 1'b0;
        oe_r[inst]   = 1'b0;
        addr_r[inst] = 4'h0;
        be_r[inst]   = 2'b00;
        drv_r[inst]  = 16'h0000;
    endtask

    task automatic op(input int inst, input bit c, input bit w, input bit r, input bit oe,
                      input logic [3:0] a, input logic [1:0] b, input logic [15:0] d);
        cs_r[inst]   = c;
        we_r[inst]   = w;
        re_r[inst]   = r;
        oe_r[inst]   = oe;
        addr_r[inst] = a;
        be_r[inst]   = b;
        drv_r[inst]  = d;
        @(negedge clk);
        drive_idle(inst);
    endtask

    task automatic wr(input int inst, input logic [3:0] a, input logic [1:0] b, input logic [15:0] d);
        op(inst, 1'b1, 1'b1, 1'b0, 1'b1, a, b, d);
    endtask

    task automatic rd(input int inst, input logic [3:0] a, input logic [15:0] exp);
        exp_t e;
        e.data = exp;
        if (inst == 0) begin
            e.due = 32'(cyc + 1);
            q_a.push_back(e);
        end else begin
            e.due = 32'(cyc + 3);
            q_b.push_back(e);
        end
        op(inst, 1'b1, 1'b0, 1'b1, 1'b0, a, 2'b00, 16'h0000);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int na;
        int nb;
        rst = 1'b1;
        drive_idle(0);
        drive_idle(1);
        idle(2);
        check("a_reset_busy", {15'b0, busy_a}, 16'h0001);
        check("a_reset_rd_valid", {15'b0, rdv_a}, 16'h0000);
        check("a_reset_err", {15'b0, err_a}, 16'h0000);
        check("b_reset_busy", {15'b0, busy_b}, 16'h0001);
        check("b_reset_rd_valid", {15'b0, rdv_b}, 16'h0000);
        check("b_reset_err", {15'b0, err_b}, 16'h0000);
        rst = 1'b0;

        // Request during clear: ignored, err pulses
        op(0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 2'b00, 16'h0000);
        check("a_err_req_in_clear", {15'b0, err_a}, 16'h0001);
        idle(1);
        check("a_err_cleared", {15'b0, err_a}, 16'h0000);
        idle(20);
        check("a_busy_done", {15'b0, busy_a}, 16'h0000);
        check("b_busy_done", {15'b0, busy_b}, 16'h0000);

        // Dirty the arrays so the later zero fill is observable
        for (int i = 0; i < 16; i++) wr(0, 4'(i), 2'b01, 16'h00FF);
        for (int i = 0; i < 16; i++) wr(1, 4'(i), 2'b11, 16'hFFFF);

        // Reset, then reset again mid-clear: fill restarts from address 0
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(5);
        #2 rst = 1'b1;
        #1 check("a_busy_mid_clear_rst", {15'b0, busy_a}, 16'h0001);
        @(negedge clk);
        rst = 1'b0;
        na = int'(busy_a);
        nb = int'(busy_b);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            na += int'(busy_a);
            nb += int'(busy_b);
        end
        check("a_busy_cycles", 16'(na), 16'd16);
        check("b_busy_cycles", 16'(nb), 16'd16);
        for (int i = 0; i < 16; i++) rd(0, 4'(i), 16'h0000);
        for (int i = 0; i < 16; i++) rd(1, 4'(i), 16'h0000);
        idle(4);

        // Write then read, RD_LAT=1
        wr(0, 4'h3, 2'b01, 16'h00A5);
        check("a_rd_valid_before", {15'b0, rdv_a}, 16'h0000);
        rd(0, 4'h3, 16'h00A5);
        check("a_rd_valid_at", {15'b0, rdv_a}, 16'h0001);
        idle(1);
        check("a_rd_valid_after", {15'b0, rdv_a}, 16'h0000);

        // Byte enables on the 16-bit instance
        wr(1, 4'h5, 2'b11, 16'h1234);
        wr(1, 4'h5, 2'b10, 16'hFF77);
        rd(1, 4'h5, 16'hFF34);
        idle(4);
        wr(1, 4'h5, 2'b00, 16'h0000);
        check("b_err_be_zero", {15'b0, err_b}, 16'h0000);
        rd(1, 4'h5, 16'hFF34);
        idle(4);

        // Back-to-back reads, RD_LAT=3 and RD_LAT=1
        wr(1, 4'h0, 2'b11, 16'h0F0F);
        wr(1, 4'h1, 2'b11, 16'hC0DE);
        wr(1, 4'h2, 2'b11, 16'hBEEF);
        wr(1, 4'h3, 2'b11, 16'h5A5A);
        rd(1, 4'h0, 16'h0F0F);
        rd(1, 4'h1, 16'hC0DE);
        rd(1, 4'h2, 16'hBEEF);
        rd(1, 4'h3, 16'h5A5A);
        idle(5);
        wr(0, 4'h7, 2'b01, 16'h003C);
        wr(0, 4'h8, 2'b01, 16'h00C3);
        rd(0, 4'h7, 16'h003C);
        rd(0, 4'h8, 16'h00C3);
        rd(0, 4'h3, 16'h00A5);
        idle(2);

        // we and re together: err, no change
        op(0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 2'b01, 16'h0000);
        check("a_err_we_re", {15'b0, err_a}, 16'h0001);
        idle(1);
        check("a_err_we_re_pulse", {15'b0, err_a}, 16'h0000);
        rd(0, 4'h3, 16'h00A5);
        idle(2);

        // cs low: nothing happens
        op(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 2'b01, 16'h0000);
        check("a_err_cs_low", {15'b0, err_a}, 16'h0000);
        rd(0, 4'h7, 16'h003C);
        idle(2);

        // Write while read data is on the bus: dropped, err
        rd(0, 4'h3, 16'h00A5);
        op(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h8, 2'b01, 16'h0000);
        check("a_err_wr_contention", {15'b0, err_a}, 16'h0001);
        idle(1);
        rd(0, 4'h8, 16'h00C3);
        idle(2);

        // Async reset while rd_valid is high
        rd(0, 4'h3, 16'h00A5);
        check("a_rd_valid_pre_rst", {15'b0, rdv_a}, 16'h0001);
        #2 rst = 1'b1;
        #1;
        check("a_rd_valid_async_rst", {15'b0, rdv_a}, 16'h0000);
        check("a_busy_async_rst", {15'b0, busy_a}, 16'h0001);
        n_chk++;
        if (bus_a === 8'hA5) begin
            n_fail++;
            $display("FAIL a_bus_released: bus still shows %h after reset", bus_a);
        end
        q_b.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        check("a_busy_after_rst", {15'b0, busy_a}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
